lock_key_sequencer: RTL and testbench

- Controller that sits in front of a logic-locked combinational core with inputs[IN_W], key[KEY_W] and out[OUT_W].
- Serially receives the key from the secure key store and holds it in a key register.
- Runs a built-in functional self-test against golden vectors from a vector ROM. The core's functional path is released only after every vector passes.
- Failed attempts are counted. Reaching the retry limit drives the block into a sticky lockout.

---
 rtl/lock_key_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_lock_key_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_key_sequencer.sv
// lock_key_sequencer
//   Front-end controller for a logic-locked combinational core. It shifts a
//   key in serially (LSB first), then self-tests the core against a golden
//   vector ROM. The functional path opens only when every vector matches.
//   Failed self-tests are counted, and reaching MAX_RETRY locks the block
//   until reset.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   start, clear          begin a key load (IDLE only) / abort and wipe key
//   key_bit, key_valid    serial key stream; key_ready is high in LOAD
//   vec_idx, vec_in,      golden ROM address and its stimulus / response
//   vec_exp
//   func_in, func_out     system-side functional path (gated)
//   core_inputs,          drive to / result from the locked core
//   core_key, core_out
//   busy, unlocked,       status flags
//   lockout, fail_cnt
module lock_key_sequencer #(
  parameter int unsigned KEY_W     = 8,
  parameter int unsigned IN_W      = 8,
  parameter int unsigned OUT_W     = 2,
  parameter int unsigned NUM_VEC   = 4,
  parameter int unsigned MAX_RETRY = 2,
  localparam int unsigned VI_W     = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1,
  localparam int unsigned FC_W     = $clog2(MAX_RETRY + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic             key_bit,
  input  logic             key_valid,
  output logic             key_ready,
  output logic [VI_W-1:0]  vec_idx,
  input  logic [IN_W-1:0]  vec_in,
  input  logic [OUT_W-1:0] vec_exp,
  input  logic [IN_W-1:0]  func_in,
  output logic [OUT_W-1:0] func_out,
  output logic [IN_W-1:0]  core_inputs,
  output logic [KEY_W-1:0] core_key,
  input  logic [OUT_W-1:0] core_out,
  output logic             busy,
  output logic             unlocked,
  output logic             lockout,
  output logic [FC_W-1:0]  fail_cnt
);

  localparam int unsigned BC_W = $clog2(KEY_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_TEST,
    S_FAIL,
    S_UNLOCKED,
    S_LOCKOUT
  } state_t;

  state_t           state, state_nxt;
  logic [KEY_W-1:0] key_reg, key_nxt;
  logic [BC_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [VI_W-1:0]  vec_idx_nxt;
  logic [FC_W-1:0]  fail_cnt_nxt;
  logic [FC_W-1:0]  fail_inc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      key_reg  <= '0;
      bit_cnt  <= '0;
      vec_idx  <= '0;
      fail_cnt <= '0;
    end else begin
      state    <= state_nxt;
      key_reg  <= key_nxt;
      bit_cnt  <= bit_cnt_nxt;
      vec_idx  <= vec_idx_nxt;
      fail_cnt <= fail_cnt_nxt;
    end
  end

  // Saturating increment of the failure counter.
  assign fail_inc = (fail_cnt == FC_W'(MAX_RETRY)) ? fail_cnt : fail_cnt + FC_W'(1);

  always_comb begin
    state_nxt    = state;
    key_nxt      = key_reg;
    bit_cnt_nxt  = bit_cnt;
    vec_idx_nxt  = vec_idx;
    fail_cnt_nxt = fail_cnt;

    case (state)
      S_IDLE: begin
        // clear has priority over a simultaneous start
        if (clear) begin
          key_nxt     = '0;
          bit_cnt_nxt = '0;
          vec_idx_nxt = '0;
        end else if (start) begin
          state_nxt   = S_LOAD;
          key_nxt     = '0;
          bit_cnt_nxt = '0;
        end
      end

      S_LOAD: begin
        if (clear) begin
          state_nxt   = S_IDLE;
          key_nxt     = '0;
          bit_cnt_nxt = '0;
          vec_idx_nxt = '0;
        end else if (key_valid) begin
          // key_reg is zeroed on entry, so OR-ing the bit in at bit_cnt
          // is equivalent to key_reg[bit_cnt] <= key_bit.
          key_nxt     = key_reg | ({{(KEY_W-1){1'b0}}, key_bit} << bit_cnt);
          bit_cnt_nxt = bit_cnt + BC_W'(1);
          if (bit_cnt == BC_W'(KEY_W - 1)) begin
            state_nxt   = S_TEST;
            vec_idx_nxt = '0;
          end
        end
      end

      S_TEST: begin
        if (clear) begin
          state_nxt   = S_IDLE;
          key_nxt     = '0;
          bit_cnt_nxt = '0;
          vec_idx_nxt = '0;
        end else if (core_out == vec_exp) begin
          if (vec_idx == VI_W'(NUM_VEC - 1)) begin
            state_nxt   = S_UNLOCKED;
            vec_idx_nxt = '0;
          end else begin
            vec_idx_nxt = vec_idx + VI_W'(1);
          end
        end else begin
          state_nxt   = S_FAIL;
          vec_idx_nxt = '0;
        end
      end

      // The failure has already occurred; a clear here cannot cancel the
      // accounting, and the key is wiped either way.
      S_FAIL: begin
        fail_cnt_nxt = fail_inc;
        key_nxt      = '0;
        bit_cnt_nxt  = '0;
        state_nxt    = (fail_inc == FC_W'(MAX_RETRY)) ? S_LOCKOUT : S_IDLE;
      end

      S_UNLOCKED: begin
        if (clear) begin
          state_nxt   = S_IDLE;
          key_nxt     = '0;
          bit_cnt_nxt = '0;
        end
      end

      S_LOCKOUT: begin
        state_nxt = S_LOCKOUT;
      end

      default: begin
        state_nxt   = S_IDLE;
        key_nxt     = '0;
        bit_cnt_nxt = '0;
        vec_idx_nxt = '0;
      end
    endcase
  end

  always_comb begin
    key_ready   = 1'b0;
    busy        = 1'b0;
    unlocked    = 1'b0;
    lockout     = 1'b0;
    core_key    = '0;
    core_inputs = '0;
    func_out    = '0;
    case (state)
      S_LOAD: begin
        key_ready = 1'b1;
        busy      = 1'b1;
      end
      S_TEST: begin
        busy        = 1'b1;
        core_key    = key_reg;
        core_inputs = vec_in;
      end
      S_UNLOCKED: begin
        unlocked    = 1'b1;
        core_key    = key_reg;
        core_inputs = func_in;
        func_out    = core_out;
      end
      S_LOCKOUT: begin
        lockout = 1'b1;
      end
      default: begin
        key_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_lock_key_sequencer.sv
// Scoreboard bench for lock_key_sequencer. Stimulus issues key-load attempts
// and pushes the predicted outcome; a monitor pops it when busy drops.
module tb_lock_key_sequencer;

  localparam int KEY_W = 8;
  localparam int IN_W = 8;
  localparam int OUT_W = 2;
  localparam int NUM_VEC = 4;
  localparam int MAX_RETRY = 2;
  localparam logic [7:0] GOOD_KEY = 8'h3C;

  localparam int K_PASS = 0;
  localparam int K_BAD = 1;
  localparam int K_ABORT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, start, clear, key_bit, key_valid, key_ready;
  logic [1:0]       vec_idx;
  logic [IN_W-1:0]  vec_in, func_in, core_inputs;
  logic [OUT_W-1:0] vec_exp, func_out, core_out;
  logic [KEY_W-1:0] core_key;
  logic             busy, unlocked, lockout;
  logic [1:0]       fail_cnt;

  lock_key_sequencer #(
    .KEY_W(KEY_W), .IN_W(IN_W), .OUT_W(OUT_W),
    .NUM_VEC(NUM_VEC), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .key_bit(key_bit), .key_valid(key_valid), .key_ready(key_ready),
    .vec_idx(vec_idx), .vec_in(vec_in), .vec_exp(vec_exp),
    .func_in(func_in), .func_out(func_out),
    .core_inputs(core_inputs), .core_key(core_key), .core_out(core_out),
    .busy(busy), .unlocked(unlocked), .lockout(lockout), .fail_cnt(fail_cnt)
  );

  // Reference core and golden ROM
  function automatic logic [1:0] core_fn(input logic [7:0] k, input logic [7:0] in);
    logic x;
    x = in[0] ^ in[4];
    return (k == GOOD_KEY) ? {x, x} : {~x, ~x};
  endfunction

  function automatic logic [7:0] rom_in(input int i);
    case (i)
      0: return 8'h01;
      1: return 8'h11;
      2: return 8'h10;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [1:0] rom_exp(input int i);
    case (i)
      0: return 2'b11;
      1: return 2'b00;
      2: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  always_comb core_out = core_fn(core_key, core_inputs);
  always_comb vec_in = rom_in(int'(vec_idx));
  always_comb vec_exp = rom_exp(int'(vec_idx));

  // Vectors consumed by a self-test with key k: stops at the first miss.
  function automatic int vectors_tested(input logic [7:0] k);
    for (int i = 0; i < NUM_VEC; i++)
      if (core_fn(k, rom_in(i)) != rom_exp(i)) return i + 1;
    return NUM_VEC;
  endfunction

  function automatic bit key_passes(input logic [7:0] k);
    for (int i = 0; i < NUM_VEC; i++)
      if (core_fn(k, rom_in(i)) != rom_exp(i)) return 1'b0;
    return 1'b1;
  endfunction

  typedef struct {
    int         kind;
    int         busy_cycles;
    logic [7:0] key;
    int         fails_after;
    bit         lock_after;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   model_fails = 0;
  bit   last_pass = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: per-cycle gating invariants plus scoreboard pops on busy fall.
  initial begin : monitor
    int   bcnt;
    bit   prev;
    bit   pend;
    exp_t e;
    bcnt = 0; prev = 0; pend = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bcnt = 0; prev = 0; pend = 0;
        continue;
      end
      if (!unlocked) check("func_out_gated", func_out, 0);
      if (!unlocked && !(busy && !key_ready)) check("core_key_hidden", core_key, 0);
      if (pend) begin
        check("fail_cnt_after", fail_cnt, e.fails_after);
        check("lockout_after", lockout, e.lock_after);
        pend = 0;
      end
      if (busy) begin
        bcnt++;
        prev = 1;
      end else if (prev) begin
        prev = 0;
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL scoreboard_empty: got busy end expected no attempt at %0t", $time);
        end else begin
          e = sb.pop_front();
          check("busy_cycles", bcnt, e.busy_cycles);
          check("unlocked_result", unlocked, e.kind == K_PASS);
          check("core_key_result", core_key, (e.kind == K_PASS) ? e.key : 8'h00);
          pend = 1;
        end
        bcnt = 0;
      end
    end
  end

  task automatic wait_settle();
    for (int t = 0; t < 200 && busy; t++) @(negedge clk);
    if (busy) begin
      n_cmp++; n_bad++;
      $display("FAIL busy_timeout: got busy=1 expected 0 at %0t", $time);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic attempt(input logic [7:0] key, input int abort_at,
                         input int gap_at, input int gap_len, input bit rgaps);
    int   lc;
    int   g;
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lc = 0;
    e.key = key;
    for (int i = 0; i < KEY_W; i++) begin
      g = (i == gap_at) ? gap_len : 0;
      if (rgaps && $urandom_range(0, 2) == 0) g += int'($urandom_range(1, 3));
      repeat (g) begin
        key_valid = 1'b0; key_bit = 1'($urandom);
        lc++;
        @(posedge clk); #1;
      end
      if (i == abort_at) begin
        clear = 1'b1;
        key_valid = 1'($urandom_range(0, 1));
        key_bit = 1'($urandom);
        lc++;
        e.kind = K_ABORT; e.busy_cycles = lc;
        e.fails_after = model_fails; e.lock_after = 0;
        sb.push_back(e);
        @(posedge clk); #1;
        clear = 1'b0; key_valid = 1'b0;
        last_pass = 1'b0;
        wait_settle();
        return;
      end
      key_valid = 1'b1; key_bit = key[i];
      lc++;
      @(posedge clk); #1;
    end
    key_valid = 1'b0;
    last_pass = key_passes(key);
    if (!last_pass && model_fails < MAX_RETRY) model_fails++;
    e.kind = last_pass ? K_PASS : K_BAD;
    e.busy_cycles = lc + vectors_tested(key);
    e.fails_after = model_fails;
    e.lock_after = (model_fails == MAX_RETRY);
    sb.push_back(e);
    wait_settle();
  endtask

  task automatic unlocked_session();
    logic [7:0] fi;
    for (int i = 0; i < 5; i++) begin
      fi = (i == 0) ? 8'h01 : 8'($urandom);
      @(posedge clk); #1;
      func_in = fi;
      @(negedge clk);
      check("func_out", func_out, core_fn(GOOD_KEY, fi));
      check("core_inputs_func", core_inputs, fi);
    end
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("start_ignored_unlocked", unlocked, 1);
    check("start_ignored_busy", busy, 0);
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    check("clear_unlocked", unlocked, 0);
    check("clear_func_out", func_out, 0);
    check("clear_core_key", core_key, 0);
    check("clear_fail_cnt", fail_cnt, model_fails);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_fails = 0;
    @(negedge clk);
    check("rst_state", {key_ready, busy, unlocked, lockout}, 0);
    check("rst_fail_cnt", fail_cnt, 0);
    check("rst_vec_idx", vec_idx, 0);
    check("rst_core_key", core_key, 0);
    check("rst_core_inputs", core_inputs, 0);
    check("rst_func_out", func_out, 0);
  endtask

  task automatic lockout_probe();
    @(posedge clk); #1;
    start = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; clear = 1'b0;
    for (int i = 0; i < KEY_W + 4; i++) begin
      key_valid = (i < KEY_W); key_bit = GOOD_KEY[i % KEY_W];
      @(negedge clk);
      check("lockout_key_ready", key_ready, 0);
      check("lockout_held", lockout, 1);
      check("lockout_not_unlocked", unlocked, 0);
      @(posedge clk); #1;
    end
    key_valid = 1'b0;
    check("lockout_fail_cnt", fail_cnt, MAX_RETRY);
  endtask

  initial begin : stim
    int         r;
    int         ab;
    logic [7:0] k;
    rst_n = 1'b0; start = 1'b0; clear = 1'b0;
    key_bit = 1'b0; key_valid = 1'b0; func_in = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Good key, back-to-back beats: 12 busy cycles then unlocked
    attempt(GOOD_KEY, -1, -1, 0, 1'b0);
    unlocked_session();

    // Wrong key: fails on vector 0
    attempt(8'h3D, -1, -1, 0, 1'b0);
    check("fail_cnt_one", fail_cnt, 1);

    // Abort after 4 bits
    attempt(GOOD_KEY, 4, -1, 0, 1'b0);
    check("abort_fail_cnt", fail_cnt, 1);

    // 3 bits, 5 idle cycles, 5 bits
    attempt(GOOD_KEY, -1, 3, 5, 1'b0);
    unlocked_session();

    // start and clear together in IDLE
    @(posedge clk); #1;
    start = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; clear = 1'b0;
    @(negedge clk);
    check("start_clear_idle", {busy, key_ready}, 0);

    // Second failure reaches the retry limit
    attempt(8'h5A, -1, -1, 0, 1'b0);
    lockout_probe();
    do_reset();

    // Two wrong loads in a row from a fresh reset
    attempt(8'h3D, -1, -1, 0, 1'b0);
    attempt(8'h00, -1, -1, 0, 1'b1);
    lockout_probe();
    do_reset();

    for (int n = 0; n < 30; n++) begin
      r = int'($urandom_range(0, 9));
      k = (r < 5) ? GOOD_KEY : 8'($urandom);
      ab = (r == 9) ? int'($urandom_range(0, KEY_W - 1)) : -1;
      attempt(k, ab, -1, 0, 1'b1);
      if (ab < 0 && last_pass) unlocked_session();
      else if (model_fails == MAX_RETRY) begin
        lockout_probe();
        do_reset();
      end
    end

    repeat (3) @(posedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
